// File: rtl/mouse_mem_if.sv
// CPU-side bus bundle for the mouse_mem peripheral: select, strobes and data.
interface mouse_mem_if;
  logic        mouse_mem_enable;
  logic        we;
  logic        re;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output mouse_mem_enable, we, re, wd, input rd);
  modport slave  (input mouse_mem_enable, we, re, wd, output rd);
endinterface

// File: rtl/mouse_mem.sv
// Memory-mapped PS/2 mouse: frame receiver, 3-byte packet assembly, clamped
// cursor accumulation and a registered read port with read-to-clear update flag.
// Optional macro MOUSE_MEM_IRQ_EN adds an irq output that mirrors the update flag.
//
// Receiver states:
//   state     | meaning
//   RX_IDLE   | waiting for a start bit (data low on a falling ps2 clock edge)
//   RX_DATA   | shifting in 8 data bits, LSB first
//   RX_PARITY | capturing the odd-parity bit
//   RX_STOP   | checking stop bit and parity, then emitting or dropping the byte
module mouse_mem #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  mouse_mem_if.slave     bus
`ifdef MOUSE_MEM_IRQ_EN
  ,
  output logic           irq
`endif
);

  localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_RELOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0] X_MAX     = 12'(SCREEN_W - 1);
  localparam logic [11:0] Y_MAX     = 12'(SCREEN_H - 1);
  localparam logic [9:0]  X_RST     = 10'(SCREEN_W / 2);
  localparam logic [8:0]  Y_RST     = 9'(SCREEN_H / 2);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev, fall;
  rx_state_t     rx_state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q, rx_byte;
  logic          par_q, byte_valid, byte_err;
  logic [TW-1:0] to_cnt;
  logic [1:0]    pkt_idx;
  logic [7:0]    b0_q, b1_q;
  logic [9:0]    x_q, x_pkt, x_wr;
  logic [8:0]    y_q, y_pkt, y_wr;
  logic [2:0]    btn_q;
  logic          upd_q;
  logic [31:0]   rd_q;
  logic [11:0]   x_sum, y_sum;
  logic          rd_sel, wr_sel, commit;
  logic          unused_bits;

  function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [11:0] hi);
    if (v[11])       return 12'd0;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  assign fall   = clk_prev & ~clk_sync[1];
  assign rd_sel = bus.mouse_mem_enable & bus.re;
  assign wr_sel = bus.mouse_mem_enable & bus.we;
  assign commit = byte_valid && (pkt_idx == 2'd2);

  // Signed 12-bit movement; Y is subtracted because screen Y grows downward.
  assign x_sum = {2'b00, x_q} + {{4{b0_q[4]}}, b1_q};
  assign y_sum = {3'b000, y_q} - {{4{b0_q[5]}}, rx_byte};
  assign x_pkt = b0_q[6] ? x_q : 10'(clamp12(x_sum, X_MAX));
  assign y_pkt = b0_q[7] ? y_q : 9'(clamp12(y_sum, Y_MAX));
  assign x_wr  = (bus.wd[25:16] > 10'(X_MAX)) ? 10'(X_MAX) : bus.wd[25:16];
  assign y_wr  = (bus.wd[8:0] > 9'(Y_MAX)) ? 9'(Y_MAX) : bus.wd[8:0];

  assign bus.rd      = rd_q;
  assign unused_bits = ^{bus.wd[31:26], bus.wd[15:9], b0_q[3]};

`ifdef MOUSE_MEM_IRQ_EN
  assign irq = upd_q;
`endif

  // Two-flop synchronisers for the pad signals plus edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  // Frame receiver with inactivity timeout; emits one-cycle valid/error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      to_cnt     <= TO_RELOAD;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      if (fall)               to_cnt <= TO_RELOAD;
      else if (to_cnt != '0)  to_cnt <= to_cnt - 1'b1;

      if (rx_state != RX_IDLE && !fall && to_cnt == '0) begin
        rx_state <= RX_IDLE;
        byte_err <= 1'b1;
      end else if (fall) begin
        unique case (rx_state)
          RX_IDLE: begin
            if (!data_sync[1]) begin
              rx_state <= RX_DATA;
              bit_cnt  <= '0;
            end
          end
          RX_DATA: begin
            shift_q <= {data_sync[1], shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state <= RX_PARITY;
          end
          RX_PARITY: begin
            par_q    <= data_sync[1];
            rx_state <= RX_STOP;
          end
          RX_STOP: begin
            if (data_sync[1] && (^{shift_q, par_q})) begin
              byte_valid <= 1'b1;
              rx_byte    <= shift_q;
            end else begin
              byte_err <= 1'b1;
            end
            rx_state <= RX_IDLE;
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // Packet assembly; a header byte must have bit3 set to resynchronise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_idx <= 2'd0;
      b0_q    <= '0;
      b1_q    <= '0;
    end else if (byte_err) begin
      pkt_idx <= 2'd0;
    end else if (byte_valid) begin
      unique case (pkt_idx)
        2'd0: if (rx_byte[3]) begin
          b0_q    <= rx_byte;
          pkt_idx <= 2'd1;
        end
        2'd1: begin
          b1_q    <= rx_byte;
          pkt_idx <= 2'd2;
        end
        default: pkt_idx <= 2'd0;
      endcase
    end
  end

  // Cursor state and read port; commit beats read-clear, CPU write beats commit on x/y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= X_RST;
      y_q   <= Y_RST;
      btn_q <= '0;
      upd_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      if (rd_sel) rd_q <= {upd_q, btn_q, 2'b00, x_q, 7'd0, y_q};

      if (commit) begin
        btn_q <= b0_q[2:0];
        upd_q <= 1'b1;
      end else if (rd_sel) begin
        upd_q <= 1'b0;
      end

      if (wr_sel) begin
        x_q <= x_wr;
        y_q <= y_wr;
      end else if (commit) begin
        x_q <= x_pkt;
        y_q <= y_pkt;
      end
    end
  end

endmodule
